// File: rtl/machine_line_parser_if.sv
// ROM fetch bus and record handshake bundle for machine_line_parser.
// master = parser side, slave = ROM/consumer side.
interface machine_line_parser_if #(
    parameter int MAX_LIGHTS  = 10,
    parameter int MAX_BUTTONS = 13,
    parameter int JOLT_BITS   = 9,
    parameter int N_ADDR_BITS = 16
);
    logic [N_ADDR_BITS:0]                rom_addr;
    logic [7:0]                          rom_data;
    logic                                rom_valid;
    logic                                rec_valid;
    logic                                rec_ready;
    logic [MAX_LIGHTS-1:0]               rec_lights;
    logic [MAX_BUTTONS*MAX_LIGHTS-1:0]   rec_buttons;
    logic [MAX_LIGHTS*JOLT_BITS-1:0]     rec_jolt;
    logic [3:0]                          rec_n_lights;
    logic [3:0]                          rec_n_buttons;
    logic [2:0]                          rec_err;

    modport master (
        output rom_addr,
        input  rom_data, rom_valid,
        output rec_valid,
        input  rec_ready,
        output rec_lights, rec_buttons, rec_jolt, rec_n_lights, rec_n_buttons, rec_err
    );

    modport slave (
        input  rom_addr,
        output rom_data, rom_valid,
        input  rec_valid,
        output rec_ready,
        input  rec_lights, rec_buttons, rec_jolt, rec_n_lights, rec_n_buttons, rec_err
    );
endinterface

// File: rtl/machine_line_parser.sv
// Streams "[.##.] (i,j) ... {a,b,..}" machine lines from ROM and emits one record per line.
// Optional statistics counters are enabled with the MACHINE_PARSER_STATS_EN macro.
//
// state  | meaning
// IDLE   | waiting for start after reset
// SEEK   | skipping bytes until '[' or end of input
// LIGHTS | reading '.'/'#' light pattern
// GAP    | between groups, expecting '(' or '{'
// BUTTON | reading comma-separated light indices of one button
// JOLT   | reading comma-separated joltage values
// CHECK  | verifying joltage count against light count
// ERR    | draining the rest of a malformed line
// EMIT   | holding the record until accepted
// EOF    | end of input, sticky until start
module machine_line_parser #(
    parameter int MAX_LIGHTS  = 10,
    parameter int MAX_BUTTONS = 13,
    parameter int JOLT_BITS   = 9,
    parameter int N_ADDR_BITS = 16,
    parameter int RD_LAT      = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    machine_line_parser_if.master  bus,
    output logic                   eof,
    output logic                   busy
`ifdef MACHINE_PARSER_STATS_EN
    ,
    output logic [31:0]            stat_lines,
    output logic [31:0]            stat_errors,
    output logic [31:0]            stat_bytes
`endif
);
    localparam int ACC_W = JOLT_BITS + 4;
    localparam int BTN_W = MAX_BUTTONS * MAX_LIGHTS;
    localparam int JLT_W = MAX_LIGHTS * JOLT_BITS;
    localparam logic [ACC_W-1:0] JOLT_MAX = ACC_W'((1 << JOLT_BITS) - 1);

    localparam logic [7:0] CH_LBRK  = 8'h5B;
    localparam logic [7:0] CH_RBRK  = 8'h5D;
    localparam logic [7:0] CH_DOT   = 8'h2E;
    localparam logic [7:0] CH_HASH  = 8'h23;
    localparam logic [7:0] CH_LPAR  = 8'h28;
    localparam logic [7:0] CH_RPAR  = 8'h29;
    localparam logic [7:0] CH_LBRC  = 8'h7B;
    localparam logic [7:0] CH_RBRC  = 8'h7D;
    localparam logic [7:0] CH_COMMA = 8'h2C;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_NL    = 8'h0A;

    localparam logic [2:0] E_LIGHT_OVF = 3'd1;
    localparam logic [2:0] E_BTN_OVF   = 3'd2;
    localparam logic [2:0] E_BAD_CHAR  = 3'd3;
    localparam logic [2:0] E_IDX_RANGE = 3'd4;
    localparam logic [2:0] E_NUM_OVF   = 3'd5;
    localparam logic [2:0] E_TRUNC     = 3'd6;
    localparam logic [2:0] E_JOLT_CNT  = 3'd7;

    typedef enum logic [3:0] {
        S_IDLE, S_SEEK, S_LIGHTS, S_GAP, S_BUTTON, S_JOLT, S_CHECK, S_ERR, S_EMIT, S_EOF
    } state_t;

    state_t state, state_nxt, err_state;

    logic [2:0]             wait_cnt;
    logic [N_ADDR_BITS:0]   addr;
    logic [MAX_LIGHTS-1:0]  lights, lights_nxt;
    logic [BTN_W-1:0]       buttons, buttons_nxt;
    logic [JLT_W-1:0]       jolt, jolt_nxt;
    logic [3:0]             light_idx, light_idx_nxt;
    logic [3:0]             n_lights, n_lights_nxt;
    logic [3:0]             button_idx, button_idx_nxt;
    logic [3:0]             jolt_idx, jolt_idx_nxt;
    logic [ACC_W-1:0]       acc, acc_nxt, acc_dig;
    logic [2:0]             err, err_nxt;
    logic                   eof_pend, eof_pend_nxt;
    logic                   clear_rec;
    logic                   fetching, sample, restart, accept;
    logic [7:0]             b;
    logic                   b_end, b_nl, b_digit;

    assign b        = bus.rom_data;
    assign b_end    = !bus.rom_valid || (b == 8'h00);
    assign b_nl     = (b == CH_NL);
    assign b_digit  = (b >= 8'h30) && (b <= 8'h39);
    assign acc_dig  = (acc << 3) + (acc << 1) + ACC_W'(b[3:0]);

    assign fetching = (state == S_SEEK) || (state == S_LIGHTS) || (state == S_GAP) ||
                      (state == S_BUTTON) || (state == S_JOLT) || (state == S_ERR);
    assign sample   = fetching && (wait_cnt == 3'(RD_LAT));
    assign restart  = start && ((state == S_IDLE) || (state == S_EOF));
    assign accept   = (state == S_EMIT) && bus.rec_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        lights_nxt     = lights;
        buttons_nxt    = buttons;
        jolt_nxt       = jolt;
        light_idx_nxt  = light_idx;
        n_lights_nxt   = n_lights;
        button_idx_nxt = button_idx;
        jolt_idx_nxt   = jolt_idx;
        acc_nxt        = acc;
        err_nxt        = err;
        eof_pend_nxt   = eof_pend;
        clear_rec      = 1'b0;
        // an offending newline/terminator already ends the line, so skip the drain
        err_state      = (b_end || b_nl) ? S_EMIT : S_ERR;

        case (state)
            S_IDLE, S_EOF: begin
                if (start) begin
                    clear_rec = 1'b1;
                    state_nxt = S_SEEK;
                end
            end
            S_SEEK: begin
                if (sample) begin
                    if (b_end) begin
                        state_nxt = S_EOF;
                    end else if (b == CH_LBRK) begin
                        clear_rec = 1'b1;
                        state_nxt = S_LIGHTS;
                    end
                end
            end
            S_LIGHTS: begin
                if (sample) begin
                    if (b_end) begin
                        err_nxt = E_TRUNC; state_nxt = err_state; eof_pend_nxt = 1'b1;
                    end else if (b == CH_DOT || b == CH_HASH) begin
                        if (light_idx == 4'(MAX_LIGHTS)) begin
                            err_nxt = E_LIGHT_OVF; state_nxt = err_state;
                        end else begin
                            for (int i = 0; i < MAX_LIGHTS; i++)
                                if (light_idx == 4'(i)) lights_nxt[i] = (b == CH_HASH);
                            light_idx_nxt = light_idx + 4'd1;
                        end
                    end else if (b == CH_RBRK) begin
                        n_lights_nxt = light_idx;
                        state_nxt    = S_GAP;
                    end else begin
                        err_nxt = E_BAD_CHAR; state_nxt = err_state;
                    end
                end
            end
            S_GAP: begin
                if (sample) begin
                    if (b_end || b_nl) begin
                        err_nxt = E_TRUNC; state_nxt = err_state; eof_pend_nxt = b_end;
                    end else if (b == CH_LPAR) begin
                        if (button_idx == 4'(MAX_BUTTONS)) begin
                            err_nxt = E_BTN_OVF; state_nxt = err_state;
                        end else begin
                            acc_nxt = '0; state_nxt = S_BUTTON;
                        end
                    end else if (b == CH_LBRC) begin
                        acc_nxt = '0; state_nxt = S_JOLT;
                    end else if (b != CH_SPACE) begin
                        err_nxt = E_BAD_CHAR; state_nxt = err_state;
                    end
                end
            end
            S_BUTTON: begin
                if (sample) begin
                    if (b_end || b_nl) begin
                        err_nxt = E_TRUNC; state_nxt = err_state; eof_pend_nxt = b_end;
                    end else if (b_digit) begin
                        acc_nxt = acc_dig;
                    end else if (b == CH_COMMA || b == CH_RPAR) begin
                        if (acc >= ACC_W'(n_lights)) begin
                            err_nxt = E_IDX_RANGE; state_nxt = err_state;
                        end else begin
                            for (int i = 0; i < MAX_BUTTONS; i++)
                                for (int k = 0; k < MAX_LIGHTS; k++)
                                    if (button_idx == 4'(i) && acc == ACC_W'(k))
                                        buttons_nxt[i*MAX_LIGHTS + k] = 1'b1;
                            acc_nxt = '0;
                            if (b == CH_RPAR) begin
                                button_idx_nxt = button_idx + 4'd1;
                                state_nxt      = S_GAP;
                            end
                        end
                    end else begin
                        err_nxt = E_BAD_CHAR; state_nxt = err_state;
                    end
                end
            end
            S_JOLT: begin
                if (sample) begin
                    if (b_end || b_nl) begin
                        err_nxt = E_TRUNC; state_nxt = err_state; eof_pend_nxt = b_end;
                    end else if (b_digit) begin
                        if (acc_dig > JOLT_MAX) begin
                            err_nxt = E_NUM_OVF; state_nxt = err_state;
                        end else begin
                            acc_nxt = acc_dig;
                        end
                    end else if (b == CH_COMMA || b == CH_RBRC) begin
                        for (int i = 0; i < MAX_LIGHTS; i++)
                            if (jolt_idx == 4'(i)) jolt_nxt[i*JOLT_BITS +: JOLT_BITS] = acc[JOLT_BITS-1:0];
                        // saturate so an over-long list can never alias back to n_lights
                        if (jolt_idx != 4'hF) jolt_idx_nxt = jolt_idx + 4'd1;
                        acc_nxt = '0;
                        if (b == CH_RBRC) state_nxt = S_CHECK;
                    end else begin
                        err_nxt = E_BAD_CHAR; state_nxt = err_state;
                    end
                end
            end
            S_CHECK: begin
                if (jolt_idx != n_lights) begin
                    err_nxt = E_JOLT_CNT; state_nxt = S_ERR;
                end else begin
                    err_nxt = '0; state_nxt = S_EMIT;
                end
            end
            S_ERR: begin
                if (sample && (b_end || b_nl)) begin
                    eof_pend_nxt = b_end;
                    state_nxt    = S_EMIT;
                end
            end
            S_EMIT: begin
                if (bus.rec_ready) begin
                    state_nxt    = eof_pend ? S_EOF : S_SEEK;
                    eof_pend_nxt = 1'b0;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        if (clear_rec) begin
            lights_nxt     = '0;
            buttons_nxt    = '0;
            jolt_nxt       = '0;
            light_idx_nxt  = '0;
            n_lights_nxt   = '0;
            button_idx_nxt = '0;
            jolt_idx_nxt   = '0;
            acc_nxt        = '0;
            err_nxt        = '0;
            eof_pend_nxt   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt   <= '0;
            addr       <= '0;
            lights     <= '0;
            buttons    <= '0;
            jolt       <= '0;
            light_idx  <= '0;
            n_lights   <= '0;
            button_idx <= '0;
            jolt_idx   <= '0;
            acc        <= '0;
            err        <= '0;
            eof_pend   <= 1'b0;
        end else begin
            if (restart)     addr <= '0;
            else if (sample) addr <= addr + 1'b1;
            if (sample || !fetching) wait_cnt <= '0;
            else                     wait_cnt <= wait_cnt + 3'd1;
            lights     <= lights_nxt;
            buttons    <= buttons_nxt;
            jolt       <= jolt_nxt;
            light_idx  <= light_idx_nxt;
            n_lights   <= n_lights_nxt;
            button_idx <= button_idx_nxt;
            jolt_idx   <= jolt_idx_nxt;
            acc        <= acc_nxt;
            err        <= err_nxt;
            eof_pend   <= eof_pend_nxt;
        end
    end

`ifdef MACHINE_PARSER_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_lines  <= '0;
            stat_errors <= '0;
            stat_bytes  <= '0;
        end else if (restart) begin
            stat_lines  <= '0;
            stat_errors <= '0;
            stat_bytes  <= '0;
        end else begin
            if (sample) stat_bytes <= stat_bytes + 32'd1;
            if (accept) begin
                stat_lines <= stat_lines + 32'd1;
                if (err != 3'd0) stat_errors <= stat_errors + 32'd1;
            end
        end
    end
`endif

    assign bus.rom_addr      = addr;
    assign bus.rec_valid     = (state == S_EMIT);
    assign bus.rec_lights    = lights;
    assign bus.rec_buttons   = buttons;
    assign bus.rec_jolt      = jolt;
    assign bus.rec_n_lights  = n_lights;
    assign bus.rec_n_buttons = button_idx;
    assign bus.rec_err       = err;
    assign eof               = (state == S_EOF);
    assign busy              = (state != S_IDLE) && (state != S_EOF);
endmodule

// File: doc/machine_line_parser.md
Name: machine_line_parser

Overview:
- Parametrised successor to the single-line machine parser used by day10_core.
- Streams ASCII machine descriptions of the form "[.##.] (3) (1,3) ... {3,5,4,7}" from ROM and emits one record per line over a valid/ready handshake.
- Runs continuously from one start pulse to EOF; ROM read latency is configurable.
- Classifies malformed lines with an error code and resynchronises at the next newline, so the solvers downstream never see stale or partial data.

Parameters:
- MAX_LIGHTS, 10, max lights per line; width of the light vector and of each button mask.
- MAX_BUTTONS, 13, max buttons per line.
- JOLT_BITS, 9, width of each joltage value.
- N_ADDR_BITS, 16, rom_addr is N_ADDR_BITS+1 bits wide.
- RD_LAT, 2, cycles from a rom_addr change to valid rom_data (range 1..7).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- start  in  1  pulse; begins parsing at address 0; ignored unless state is IDLE or EOF
- rom_addr  out  N_ADDR_BITS+1  byte address
- rom_data  in  8  byte at rom_addr, valid RD_LAT cycles after the address changes
- rom_valid  in  1  low means past end of ROM
- rec_valid  out  1  record available
- rec_ready  in  1  consumer accepts the record
- rec_lights  out  MAX_LIGHTS  target pattern; bit i = light i is '#'
- rec_buttons  out  MAX_BUTTONS*MAX_LIGHTS  button b mask at [b*MAX_LIGHTS +: MAX_LIGHTS]
- rec_jolt  out  MAX_LIGHTS*JOLT_BITS  joltage j at [j*JOLT_BITS +: JOLT_BITS]
- rec_n_lights  out  4  light count
- rec_n_buttons  out  4  button count
- rec_err  out  3  0 = OK, else error code
- eof  out  1  end of input reached
- busy  out  1  high in any state other than IDLE and EOF

Interface: one clock (clk); reset rst is asynchronous, active-high.

Behaviour:
Reset:
- All outputs 0, rom_addr 0, state IDLE.
- A reset asserted mid-line aborts immediately; no record is emitted.

Fetch:
- Every byte consumed costs RD_LAT+1 cycles: rom_addr is held, a wait counter counts 0..RD_LAT, and rom_data is sampled at count RD_LAT.
- rom_addr increments by 1 in the sampling cycle.

States:
- IDLE: on start, clear the working record and go to SEEK.
- SEEK:
  - !rom_valid or byte 0x00 -> EOF.
  - '[' -> LIGHTS.
  - Any other byte is skipped.
- LIGHTS:
  - '.' or '#' writes bit light_idx and increments light_idx.
  - ']' latches n_lights and goes to GAP.
  - Another character -> ERR with code 3 (BAD_CHAR).
  - light_idx = MAX_LIGHTS when '.' or '#' arrives -> ERR with code 1 (LIGHT_OVF).
- GAP:
  - '(' -> BUTTON; button_idx = MAX_BUTTONS at '(' -> ERR with code 2 (BTN_OVF).
  - '{' -> JOLT.
  - Space skipped; '\n' or EOF -> ERR with code 6 (TRUNC).
  - Other bytes -> ERR with code 3.
- BUTTON:
  - Digits accumulate acc = acc*10 + d.
  - ',' or ')' commits bit acc of the current button mask; acc >= n_lights -> ERR with code 4 (IDX_RANGE).
  - ')' increments button_idx and returns to GAP.
- JOLT:
  - Digits accumulate; a result exceeding 2^JOLT_BITS-1 -> ERR with code 5 (NUM_OVF).
  - ',' or '}' stores the value at jolt_idx.
  - '}' goes to CHECK.
- CHECK: jolt_idx != n_lights -> ERR with code 7 (JOLT_CNT); else EMIT with rec_err = 0.
- ERR: latches the error code, then drains bytes until '\n', !rom_valid or 0x00, then goes to EMIT.
  - A record is emitted for every error line; payload fields hold whatever was parsed before the error.
- EMIT:
  - rec_valid = 1 with all rec_* fields stable; no fetch occurs while waiting.
  - On rec_valid & rec_ready: rec_valid drops next cycle and state goes to SEEK.
  - If the ERR drain ended on EOF, state goes to EOF instead of SEEK.
  - rec_ready asserted while rec_valid is low has no effect.
- EOF: eof = 1, sticky; start restarts from address 0 and clears eof.

Counts and accumulator:
- Unused mask and joltage slots are zero in every record.
- The accumulator has JOLT_BITS+4 bits; overflow is checked on every digit.
- For button indices the only check is acc >= n_lights.
- rom_addr wraps modulo 2^(N_ADDR_BITS+1); rom_valid is expected to fall before the wrap.

Optional Feature:
- Macro: MACHINE_PARSER_STATS_EN.
- When defined, three extra outputs exist:
  - stat_lines (32): records emitted.
  - stat_errors (32): records with rec_err != 0.
  - stat_bytes (32): bytes sampled.
- All three reset to 0 and are cleared on an accepted start.
- stat_lines and stat_errors update in the handshake cycle.
- When not defined, these ports and counters are absent; the rest of the behaviour is identical.

Test Plan:
1. Line "[.##.] (3) (1,3) (2) (2,3) (0,2) (0,1) {3,5,4,7}\n" then 0x00, rec_ready = 1 -> one record:
   - lights = 4'b0110, n_lights = 4, n_buttons = 6.
   - Masks 1000, 1010, 0100, 1100, 0101, 0011.
   - jolt = 3, 5, 4, 7; rec_err = 0.
   - eof = 1 afterwards.
2. Same line with rec_ready held low for 20 cycles -> rec_valid stays 1; payload and rom_addr stay constant; the record is accepted on the first rec_ready cycle.
3. Run scenario 1 at RD_LAT = 1 and RD_LAT = 4 -> identical record; the byte spacing seen on rom_addr is 2 and 5 cycles respectively.
4. Three lines where the middle one is "[##] (5) {1,2}" -> records with rec_err 0, 4, 0; the third line parses correctly after resync.
5. Line "[#.] (0) {1}" -> rec_err = 7. Line "{999...}" with a value of 600 -> rec_err = 5.
6. Reset asserted during BUTTON parsing -> outputs zero asynchronously; a new start re-parses line 1 from address 0.
